branch_resolve_unit: RTL and testbench

D-stage branch resolution unit for the pipelined MIPS core. Compares two forwarded operands under a selectable branch condition and owns a 2-bit saturating branch history table (BHT). The F stage reads a prediction from the BHT; the D stage checks the actual outcome against that prediction, updates the table and raises a mispredict flush. Width, forwarding-source count and BHT depth are parameters; the unit also keeps branch and mispredict statistics counters.

---
 rtl/br_pkg.sv | 29 ++
 rtl/branch_resolve_unit_if.sv | 42 ++++
 rtl/bht_2bit.sv | 39 +++
 rtl/branch_resolve_unit.sv | 96 +++++++++
 tb/tb_branch_resolve_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_pkg.sv
// Shared constants and helpers for branch resolution.
// Holds condition codes, BHT counter states and the 2-bit saturating update.
package br_pkg;

   localparam logic [2:0] BR_EQ     = 3'd0;
   localparam logic [2:0] BR_NE     = 3'd1;
   localparam logic [2:0] BR_LEZ    = 3'd2;
   localparam logic [2:0] BR_GTZ    = 3'd3;
   localparam logic [2:0] BR_LTZ    = 3'd4;
   localparam logic [2:0] BR_GEZ    = 3'd5;
   localparam logic [2:0] BR_ALWAYS = 3'd6;
   localparam logic [2:0] BR_RSVD   = 3'd7;

   localparam logic [1:0] BHT_SNT = 2'b00;
   localparam logic [1:0] BHT_WNT = 2'b01;
   localparam logic [1:0] BHT_WT  = 2'b10;
   localparam logic [1:0] BHT_ST  = 2'b11;

   function automatic logic [1:0] bht_sat(
      input logic [1:0] cur,
      input logic       taken
   );
      if (taken)
         return (cur == BHT_ST) ? BHT_ST : cur + 2'd1;
      else
         return (cur == BHT_SNT) ? BHT_SNT : cur - 2'd1;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// D-stage branch bus between the pipeline (master) and the resolve unit (slave).
// Carries fetch lookup, branch operands/forwarding, outcome and statistics.
interface branch_resolve_unit_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_FWD = 2
);
   localparam int SEL_W = $clog2(NUM_FWD + 1);

   logic [WIDTH-1:0]         f_pc;
   logic                     f_pred_taken;
   logic                     d_valid;
   logic                     d_stall;
   logic [2:0]               d_cond;
   logic [WIDTH-1:0]         d_pc;
   logic                     d_pred_taken;
   logic [WIDTH-1:0]         rd1;
   logic [WIDTH-1:0]         rd2;
   logic [SEL_W-1:0]         rs_sel;
   logic [SEL_W-1:0]         rt_sel;
   logic [NUM_FWD*WIDTH-1:0] fwd_data;
   logic                     br_taken;
   logic                     br_mispredict;
   logic [31:0]              branch_cnt;
   logic [31:0]              mispred_cnt;

   modport master (
      output f_pc, d_valid, d_stall, d_cond, d_pc,
      output d_pred_taken, rd1, rd2, rs_sel, rt_sel,
      output fwd_data,
      input  f_pred_taken, br_taken, br_mispredict,
      input  branch_cnt, mispred_cnt
   );

   modport slave (
      input  f_pc, d_valid, d_stall, d_cond, d_pc,
      input  d_pred_taken, rd1, rd2, rs_sel, rt_sel,
      input  fwd_data,
      output f_pred_taken, br_taken, br_mispredict,
      output branch_cnt, mispred_cnt
   );

endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters, reset to weakly not-taken.
// Ports: clk, reset, rd_idx/rd_pred (comb read), wr_en/wr_idx/wr_taken (sync update).
module bht_2bit
   import br_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_pred,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   logic [1:0] bht_q [ENTRIES];
   logic [1:0] bht_d [ENTRIES];

   // Read sees the stored value; a same-cycle write lands next cycle.
   assign rd_pred = bht_q[rd_idx][1];

   always_comb begin
      bht_d = bht_q;
      if (wr_en)
         bht_d[wr_idx] = bht_sat(bht_q[wr_idx], wr_taken);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++)
            bht_q[i] <= BHT_WNT;
      end else begin
         bht_q <= bht_d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// D-stage branch resolution: operand forwarding mux, condition check, BHT, stats.
// Ports: clk, reset (sync, active-high), bus (slave side of branch_resolve_unit_if).
module branch_resolve_unit
   import br_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NUM_FWD     = 2,
   parameter int BHT_ENTRIES = 64,
   localparam int SEL_W      = $clog2(NUM_FWD + 1),
   localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 reset,
   branch_resolve_unit_if.slave bus
);

   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             cond_res;
   logic             br_taken;
   logic             res;
   logic             mispred;
   logic [31:0]      branch_cnt_q, branch_cnt_d;
   logic [31:0]      mispred_cnt_q, mispred_cnt_d;

   // Selects outside 1..NUM_FWD fall back to the regfile value.
   always_comb begin
      rs_val = bus.rd1;
      rt_val = bus.rd2;
      for (int k = 1; k <= NUM_FWD; k++) begin
         if (bus.rs_sel == SEL_W'(k))
            rs_val = bus.fwd_data[(k-1)*WIDTH +: WIDTH];
         if (bus.rt_sel == SEL_W'(k))
            rt_val = bus.fwd_data[(k-1)*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      cond_res = 1'b0;
      case (bus.d_cond)
         BR_EQ:     cond_res = (rs_val == rt_val);
         BR_NE:     cond_res = (rs_val != rt_val);
         BR_LEZ:    cond_res = rs_val[WIDTH-1] | (rs_val == '0);
         BR_GTZ:    cond_res = ~rs_val[WIDTH-1] & (rs_val != '0);
         BR_LTZ:    cond_res = rs_val[WIDTH-1];
         BR_GEZ:    cond_res = ~rs_val[WIDTH-1];
         BR_ALWAYS: cond_res = 1'b1;
         default:   cond_res = 1'b0;
      endcase
   end

   assign br_taken = bus.d_valid & cond_res;
   assign res      = bus.d_valid & ~bus.d_stall & ~reset;
   // Stalled operands may still be in flight, so no flush then.
   assign mispred  = res & (br_taken != bus.d_pred_taken);

   assign bus.br_taken      = br_taken;
   assign bus.br_mispredict = mispred;

   bht_2bit #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (bus.f_pc[IDX_W+1:2]),
      .rd_pred  (bus.f_pred_taken),
      .wr_en    (res),
      .wr_idx   (bus.d_pc[IDX_W+1:2]),
      .wr_taken (br_taken)
   );

   // Statistics saturate rather than wrap.
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (res && branch_cnt_q != '1)
         branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispred && mispred_cnt_q != '1)
         mispred_cnt_d = mispred_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bus.branch_cnt  = branch_cnt_q;
   assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit.
// Compares DUT against a behavioural model of the BHT, outcome and counters.
module tb_branch_resolve_unit;

   localparam int WIDTH       = 32;
   localparam int NUM_FWD     = 2;
   localparam int BHT_ENTRIES = 64;
   localparam int SEL_W       = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(
      .WIDTH   (WIDTH),
      .NUM_FWD (NUM_FWD)
   ) bus ();

   branch_resolve_unit #(
      .WIDTH       (WIDTH),
      .NUM_FWD     (NUM_FWD),
      .BHT_ENTRIES (BHT_ENTRIES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [WIDTH-1:0] fwd_arr [NUM_FWD];

   for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
      assign bus.fwd_data[k*WIDTH +: WIDTH] = fwd_arr[k];
   end

   int vectors     = 0;
   int miscompares = 0;

   int              bht_m [BHT_ENTRIES];
   longint unsigned bcnt_m;
   longint unsigned mcnt_m;
   bit              model_ok = 1'b0;
   bit              exp_taken;
   bit              exp_mis;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] pick(int sel, logic [WIDTH-1:0] rd);
      if (sel >= 1 && sel <= NUM_FWD)
         return fwd_arr[sel-1];
      return rd;
   endfunction

   function automatic bit eval(int cond,
                               logic signed [WIDTH-1:0] a,
                               logic signed [WIDTH-1:0] b);
      case (cond)
         0:       return a == b;
         1:       return a != b;
         2:       return a <= 0;
         3:       return a > 0;
         4:       return a < 0;
         5:       return a >= 0;
         6:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int idx_of(logic [WIDTH-1:0] pc);
      return int'((pc >> 2) % BHT_ENTRIES);
   endfunction

   // Compare every output against the model for the current inputs.
   task automatic settle();
      logic [WIDTH-1:0] a, b;
      #1;
      a = pick(int'(bus.rs_sel), bus.rd1);
      b = pick(int'(bus.rt_sel), bus.rd2);
      exp_taken = bus.d_valid && eval(int'(bus.d_cond), a, b);
      exp_mis   = bus.d_valid && !bus.d_stall && !reset
                  && (exp_taken != bus.d_pred_taken);
      chk("br_taken", 32'(bus.br_taken), 32'(exp_taken));
      chk("br_mispredict", 32'(bus.br_mispredict), 32'(exp_mis));
      if (model_ok) begin
         chk("f_pred_taken", 32'(bus.f_pred_taken),
             32'(bht_m[idx_of(bus.f_pc)] >= 2));
         chk("branch_cnt", bus.branch_cnt, bcnt_m[31:0]);
         chk("mispred_cnt", bus.mispred_cnt, mcnt_m[31:0]);
      end
   endtask

   task automatic advance();
      int i;
      @(posedge clk);
      if (reset) begin
         foreach (bht_m[j]) bht_m[j] = 1;
         bcnt_m   = 0;
         mcnt_m   = 0;
         model_ok = 1'b1;
      end else if (bus.d_valid && !bus.d_stall) begin
         i = idx_of(bus.d_pc);
         if (exp_taken) bht_m[i] = (bht_m[i] < 3) ? bht_m[i] + 1 : 3;
         else           bht_m[i] = (bht_m[i] > 0) ? bht_m[i] - 1 : 0;
         if (bcnt_m < 64'hFFFF_FFFF) bcnt_m++;
         if (exp_mis && mcnt_m < 64'hFFFF_FFFF) mcnt_m++;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      reset            = 1'b0;
      bus.d_valid      = 1'b0;
      bus.d_stall      = 1'b0;
      bus.d_cond       = 3'd0;
      bus.d_pc         = '0;
      bus.d_pred_taken = 1'b0;
      bus.rd1          = '0;
      bus.rd2          = '0;
      bus.rs_sel       = '0;
      bus.rt_sel       = '0;
      fwd_arr[0]       = '0;
      fwd_arr[1]       = '0;
   endtask

   task automatic branch(logic [2:0] cond, logic [WIDTH-1:0] pc, logic pred);
      bus.d_valid      = 1'b1;
      bus.d_stall      = 1'b0;
      bus.d_cond       = cond;
      bus.d_pc         = pc;
      bus.d_pred_taken = pred;
   endtask

   function automatic logic [WIDTH-1:0] rand_val();
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return 32'd5;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive_rand();
      reset            = ($urandom_range(0, 199) == 0);
      bus.d_valid      = ($urandom_range(0, 9) < 7);
      bus.d_stall      = ($urandom_range(0, 4) == 0);
      bus.d_cond       = 3'($urandom_range(0, 7));
      bus.d_pred_taken = 1'($urandom_range(0, 1));
      bus.d_pc         = WIDTH'(($urandom_range(0, 7) << 2)
                                | ($urandom_range(0, 1) << 8));
      if ($urandom_range(0, 1) == 0)
         bus.f_pc = bus.d_pc;
      else
         bus.f_pc = WIDTH'(($urandom_range(0, 7) << 2)
                           | ($urandom_range(0, 1) << 9));
      bus.rd1    = rand_val();
      bus.rd2    = ($urandom_range(0, 1) == 0) ? bus.rd1 : rand_val();
      fwd_arr[0] = ($urandom_range(0, 2) == 0) ? bus.rd2 : rand_val();
      fwd_arr[1] = rand_val();
      bus.rs_sel = SEL_W'($urandom_range(0, 3));
      bus.rt_sel = SEL_W'($urandom_range(0, 3));
   endtask

   initial begin
      idle();
      bus.f_pc = '0;
      reset    = 1'b1;
      @(negedge clk);

      // Reset state
      settle();
      advance();
      idle();
      bus.f_pc = 32'h0000_3000;
      settle();
      chk("rst_f_pred", 32'(bus.f_pred_taken), 32'd0);
      chk("rst_bcnt", bus.branch_cnt, 32'd0);
      chk("rst_mcnt", bus.mispred_cnt, 32'd0);

      // EQ taken, predicted not-taken
      branch(3'd0, 32'h3000, 1'b0);
      bus.rd1 = 32'd5;
      bus.rd2 = 32'd5;
      settle();
      chk("eq_taken", 32'(bus.br_taken), 32'd1);
      chk("eq_mis", 32'(bus.br_mispredict), 32'd1);
      advance();
      idle();
      settle();
      chk("eq_f_pred", 32'(bus.f_pred_taken), 32'd1);
      chk("eq_bcnt", bus.branch_cnt, 32'd1);
      chk("eq_mcnt", bus.mispred_cnt, 32'd1);

      // LTZ via forward slot 0, then out-of-range select
      branch(3'd4, 32'h3100, 1'b1);
      bus.rs_sel = 2'd1;
      fwd_arr[0] = 32'hFFFF_FFFF;
      settle();
      chk("ltz_fwd", 32'(bus.br_taken), 32'd1);
      advance();
      bus.rs_sel = 2'd3;
      settle();
      chk("ltz_sel3", 32'(bus.br_taken), 32'd0);
      advance();

      // Stall suppresses flush and updates
      idle();
      branch(3'd6, 32'h3000, 1'b0);
      bus.d_stall = 1'b1;
      settle();
      chk("stall_mis", 32'(bus.br_mispredict), 32'd0);
      advance();
      idle();
      settle();
      chk("stall_bcnt", bus.branch_cnt, 32'd3);
      chk("stall_mcnt", bus.mispred_cnt, 32'd2);
      chk("stall_f_pred", 32'(bus.f_pred_taken), 32'd1);

      // Saturation walk at 0x3000 from reset
      reset = 1'b1;
      settle();
      advance();
      idle();
      for (int n = 0; n < 4; n++) begin
         branch(3'd6, 32'h3000, 1'b1);
         settle();
         if (n == 0)
            chk("no_bypass", 32'(bus.f_pred_taken), 32'd0);
         advance();
      end
      idle();
      settle();
      chk("sat_st", 32'(bus.f_pred_taken), 32'd1);
      branch(3'd7, 32'h3000, 1'b1);
      settle();
      chk("nt_old", 32'(bus.f_pred_taken), 32'd1);
      advance();
      idle();
      settle();
      chk("wt_pred", 32'(bus.f_pred_taken), 32'd1);
      branch(3'd7, 32'h3000, 1'b1);
      settle();
      advance();
      idle();
      settle();
      chk("wnt_pred", 32'(bus.f_pred_taken), 32'd0);

      // Reset beats a same-cycle mispredict
      branch(3'd6, 32'h3000, 1'b0);
      reset = 1'b1;
      settle();
      chk("rst_mis", 32'(bus.br_mispredict), 32'd0);
      advance();
      idle();
      bus.f_pc = 32'h0;
      settle();
      chk("rst2_idx0", 32'(bus.f_pred_taken), 32'd0);
      chk("rst2_bcnt", bus.branch_cnt, 32'd0);
      chk("rst2_mcnt", bus.mispred_cnt, 32'd0);
      bus.f_pc = WIDTH'((BHT_ENTRIES - 1) << 2);
      settle();
      chk("rst2_idxN", 32'(bus.f_pred_taken), 32'd0);
      // One taken step from WNT must predict taken
      branch(3'd6, WIDTH'((BHT_ENTRIES - 1) << 2), 1'b0);
      settle();
      advance();
      idle();
      bus.f_pc = WIDTH'((BHT_ENTRIES - 1) << 2);
      settle();
      chk("rst2_wnt", 32'(bus.f_pred_taken), 32'd1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         drive_rand();
         settle();
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
